seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode/cathode 7-segment display.
- One shared hex-to-segment decoder drives all digits; this block sequences digit select, decoder input, DP and blanking.
- Double-buffered load interface: host writes a new value at any time, and the display commits it only at frame boundaries so no tearing is visible.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; range 2..8.
- SLOT_CYC, 50000, clock cycles per digit slot; must be ≥ GUARD_CYC+1.
- GUARD_CYC, 16, cycles at the start of each slot with all digits off (anti-ghosting); must be ≥ 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable.
- load  in  1  single-cycle strobe; captures value/dp_in.
- value  in  4*NUM_DIGITS  hex nibbles; nibble 0 (bits 3:0) is the rightmost/least-significant digit.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1=lit.
- blank_lz  in  1  leading-zero suppression enable (level, sampled every cycle).
- seg_out  out  7  segments, active-high; bit6=a … bit0=g.
- dp_out  out  1  decimal point of the selected digit, active-high.
- digit_sel  out  NUM_DIGITS  one-hot active-high digit enable; all-zero when dark.
- frame_done  out  1  one-cycle pulse at the end of the last digit slot.
- pending  out  1  a loaded value is waiting to be committed.

Behaviour:
- Reset (async, rst_n=0): seg_out=0, dp_out=0, digit_sel=0, frame_done=0, pending=0. Active and pending buffers are cleared to 0, digit index=0, slot counter=0, state=GUARD.
- All outputs are registered. digit_sel, seg_out and dp_out change together on the same edge.
- Slot counter runs 0..SLOT_CYC-1, then wraps to 0 and digit index increments. Digit index wraps from NUM_DIGITS-1 to 0.
- FSM, two states:
  - GUARD: counter < GUARD_CYC. digit_sel=0, seg_out=0, dp_out=0.
  - DRIVE: counter ≥ GUARD_CYC. digit_sel=1<<idx, seg_out=decode(active nibble idx) or 0 if blanked, dp_out=active_dp[idx].
  - GUARD→DRIVE when counter reaches GUARD_CYC. DRIVE→GUARD on counter wrap.
- Frame boundary: the cycle in which counter wraps with idx=NUM_DIGITS-1. In that cycle frame_done=1 on the following edge (one cycle high). If pending=1, active←pending buffer and pending→0.
- load while en=1: pending buffer←{value,dp_in}, pending→1. A later load before the boundary overwrites the pending buffer (last write wins).
- load coincident with the frame boundary: the new load data commits directly to active; pending ends 0.
- Leading-zero blanking (blank_lz=1): a digit is blanked if it and every higher digit have nibble=0 and dp=0. Digit 0 is never blanked. A blanked digit still gets its slot: digit_sel asserted, seg_out=0, dp_out=0.
- en=0:
  - Outputs dark (digit_sel=0, seg_out=0, dp_out=0). Counter and idx held at 0, state=GUARD, frame_done=0.
  - load commits straight to active; pending stays 0.
  - Any existing pending buffer commits on the first cycle of en=0.
- en 0→1: scan starts at idx 0, counter 0 (a GUARD phase first).
- en 1→0 mid-slot: outputs go dark on the next edge; no partial frame_done.
- Reset mid-frame: immediate dark outputs; the pending value is lost.

Decomposition:
- Shared package seg7_pkg:
  - SEG_BLANK=7'b0000000.
  - Segment bit-index constants A..G.
  - Function clog2 for index/counter widths.
  - Type/width constant for one digit record {nibble, dp}.
- One sub-module: seg7_slot_timer.
  - Contains the slot counter, digit index and GUARD/DRIVE FSM.
  - Outputs idx, in_guard, frame_boundary.
- The team's hex-to-segment decoder is instantiated once, combinationally, between the active-buffer mux and the output register.

Test Plan (NUM_DIGITS=4, SLOT_CYC=8, GUARD_CYC=2):
- Reset, then en=1, load value=16'h1234, dp_in=0 → pending=1 until the first boundary.
  - Next frame, each slot shows 2 dark cycles then 6 DRIVE cycles.
  - idx0: digit_sel=0001, seg=7'b0110011 (4). idx3: digit_sel=1000, seg=7'b0110000 (1).
  - frame_done pulses once every 32 cycles.
- Load 16'h5555 at idx1 of a frame → the remaining digits of that frame still show 16'h1234 values. Next frame digit 0 shows seg=7'b1011011 (5).
- blank_lz=1, value=16'h0050, dp_in=0 → digits 3 and 2 show seg=0 with digit_sel still asserted; digit 1=5, digit 0=0 (7'b1111110).
  - With dp_in=4'b1000, digit 3 is not blanked.
- load asserted in the exact boundary cycle, plus a second load one cycle earlier → the boundary-cycle data is displayed next frame; pending=0.
- Drop en at counter 5 of idx2 → all outputs 0 on the next edge, no frame_done; re-enable → scan resumes at idx0 with a GUARD phase.
- Assert rst_n=0 asynchronously mid-DRIVE → seg_out, digit_sel and pending are 0 before the next clock edge; after release the display shows 0000.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, digit record and width helper for the 7-segment scan controller
package seg7_pkg;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;
   typedef struct packed {
      logic [3:0] nib;
      logic       dp;
   } digit_t;
   localparam int DIGIT_W = $bits(digit_t);
   function automatic int clog2(input int v);
      int r = 1;
      for (int i = 1; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
      return r;
   endfunction
endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: hex nibble to active-high a..g segments (bit6=a .. bit0=g)
module seg7_hex_dec
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);
   // bit n of each mask is set when that segment is lit for hex digit n
   localparam logic [15:0] LIT_A = 16'hD7ED;
   localparam logic [15:0] LIT_B = 16'h279F;
   localparam logic [15:0] LIT_C = 16'h2FFB;
   localparam logic [15:0] LIT_D = 16'h7B6D;
   localparam logic [15:0] LIT_E = 16'hFD45;
   localparam logic [15:0] LIT_F = 16'hDF71;
   localparam logic [15:0] LIT_G = 16'hEF7C;
   always_comb begin
      seg_o        = SEG_BLANK;
      seg_o[SEG_A] = LIT_A[nib_i];
      seg_o[SEG_B] = LIT_B[nib_i];
      seg_o[SEG_C] = LIT_C[nib_i];
      seg_o[SEG_D] = LIT_D[nib_i];
      seg_o[SEG_E] = LIT_E[nib_i];
      seg_o[SEG_F] = LIT_F[nib_i];
      seg_o[SEG_G] = LIT_G[nib_i];
   end
endmodule

// File: rtl/seg7_slot_timer.sv
// seg7_slot_timer: slot counter, digit index and GUARD/DRIVE sequencing
module seg7_slot_timer
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SLOT_CYC   = 50000,
   parameter int GUARD_CYC  = 16,
   parameter int IDX_W      = clog2(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             in_guard_o,
   output logic             frame_boundary_o
);
   localparam int CNT_W = clog2(SLOT_CYC);
   localparam logic [0:0] GUARD = 1'b0;
   localparam logic [0:0] DRIVE = 1'b1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [0:0]       state_q, state_d;
   logic             wrap, last;
   always_comb begin
      wrap    = cnt_q == CNT_W'(SLOT_CYC - 1);
      last    = idx_q == IDX_W'(NUM_DIGITS - 1);
      cnt_d   = (!en_i || wrap) ? '0 : cnt_q + 1'b1;
      idx_d   = !en_i ? '0 : !wrap ? idx_q : last ? '0 : idx_q + 1'b1;
      // state_q tracks cnt_q: DRIVE exactly while cnt_q >= GUARD_CYC
      state_d = (!en_i || wrap) ? GUARD : (cnt_q == CNT_W'(GUARD_CYC - 1)) ? DRIVE : state_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         state_q <= GUARD;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
      end
   end
   assign idx_o            = idx_q;
   assign in_guard_o       = state_q == GUARD;
   assign frame_boundary_o = en_i && wrap && last;
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed N-digit 7-segment scanner with frame-synchronous double buffering
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SLOT_CYC   = 50000,
   parameter int GUARD_CYC  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done,
   output logic                    pending
);
   localparam int IDX_W = clog2(NUM_DIGITS);
   logic [IDX_W-1:0]        idx;
   logic                    in_guard, frame_boundary;
   logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                    pending_q, pending_d;
   logic [NUM_DIGITS-1:0]   sel_q, sel_d, lz;
   logic [6:0]              seg_q, seg_d, dec_seg;
   logic                    dp_q, dp_d, fd_q;
   logic                    commit, drive, show, run;
   digit_t                  cur;
   seg7_slot_timer #(
      .NUM_DIGITS(NUM_DIGITS),
      .SLOT_CYC  (SLOT_CYC),
      .GUARD_CYC (GUARD_CYC),
      .IDX_W     (IDX_W)
   ) u_timer (
      .clk             (clk),
      .rst_n           (rst_n),
      .en_i            (en),
      .idx_o           (idx),
      .in_guard_o      (in_guard),
      .frame_boundary_o(frame_boundary)
   );
   seg7_hex_dec u_dec (
      .nib_i(cur.nib),
      .seg_o(dec_seg)
   );
   // while disabled every cycle acts as a frame boundary, so loads bypass the pending buffer
   always_comb begin
      commit     = !en || frame_boundary;
      act_val_d  = (commit && load) ? value : (commit && pending_q) ? pend_val_q : act_val_q;
      act_dp_d   = (commit && load) ? dp_in : (commit && pending_q) ? pend_dp_q : act_dp_q;
      pend_val_d = (load && !commit) ? value : pend_val_q;
      pend_dp_d  = (load && !commit) ? dp_in : pend_dp_q;
      pending_d  = commit ? 1'b0 : load ? 1'b1 : pending_q;
   end
   // lz[k]: digit k and all higher digits are zero with no decimal point
   always_comb begin
      run = 1'b1;
      lz  = '0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         run   = run && (act_val_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
         lz[k] = run;
      end
   end
   always_comb begin
      cur   = '{nib: act_val_q[{idx, 2'b00} +: 4], dp: act_dp_q[idx]};
      drive = en && !in_guard;
      show  = drive && !(blank_lz && lz[idx]);
      sel_d = drive ? {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx : '0;
      seg_d = show ? dec_seg : SEG_BLANK;
      dp_d  = show && cur.dp;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_val_q  <= '0;
         act_dp_q   <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pending_q  <= 1'b0;
         sel_q      <= '0;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b0;
         fd_q       <= 1'b0;
      end else begin
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pending_q  <= pending_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
         fd_q       <= frame_boundary;
      end
   end
   assign seg_out    = seg_q;
   assign dp_out     = dp_q;
   assign digit_sel  = sel_q;
   assign frame_done = fd_q;
   assign pending    = pending_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table-driven frame checks plus directed corner sequences (4 digits, 8-cycle slots, 2 guard)
module tb_seg7_scan_ctrl;
   localparam logic [6:0] BLK = 7'b0000000;
   localparam logic [6:0] H0  = 7'b1111110;
   localparam logic [6:0] H1  = 7'b0110000;
   localparam logic [6:0] H2  = 7'b1101101;
   localparam logic [6:0] H3  = 7'b1111001;
   localparam logic [6:0] H4  = 7'b0110011;
   localparam logic [6:0] H5  = 7'b1011011;
   localparam logic [6:0] H6  = 7'b1011111;
   localparam logic [6:0] H7  = 7'b1110000;
   localparam logic [6:0] H8  = 7'b1111111;
   localparam logic [6:0] H9  = 7'b1111011;
   localparam logic [6:0] HA  = 7'b1110111;
   localparam logic [6:0] HB  = 7'b0011111;
   localparam logic [6:0] HC  = 7'b1001110;
   localparam logic [6:0] HD  = 7'b0111101;
   localparam logic [6:0] HE  = 7'b1001111;
   localparam logic [6:0] HF  = 7'b1000111;
   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dp;
      logic        blz;
      logic [27:0] segs;
      logic [3:0]  edp;
   } vec_t;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, blank_lz = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg_out;
   logic        dp_out, frame_done, pending;
   logic [3:0]  digit_sel;
   int          checks = 0, failures = 0;
   vec_t        tbl [7];
   always #5 clk = ~clk;
   seg7_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYC(8), .GUARD_CYC(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .load      (load),
      .value     (value),
      .dp_in     (dp_in),
      .blank_lz  (blank_lz),
      .seg_out   (seg_out),
      .dp_out    (dp_out),
      .digit_sel (digit_sel),
      .frame_done(frame_done),
      .pending   (pending)
   );
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic wait_fd();
      int n = 0;
      do begin
         step();
         n++;
      end while (!frame_done && n < 40);
      chk("frame_done_wait", 32'(frame_done), 32'd1);
   endtask
   task automatic drive_chk(input string name, input logic [3:0] sel, input logic [6:0] seg);
      chk({name, "_sel"}, 32'(digit_sel), 32'(sel));
      chk({name, "_seg"}, 32'(seg_out), 32'(seg));
   endtask
   initial begin
      logic fd_seen, sel_seen;
      tbl[0] = '{value: 16'h0050, dp: 4'b0000, blz: 1'b1, segs: {BLK, BLK, H5, H0}, edp: 4'b0000};
      tbl[1] = '{value: 16'h0050, dp: 4'b1000, blz: 1'b1, segs: {H0, H0, H5, H0}, edp: 4'b1000};
      tbl[2] = '{value: 16'hABCD, dp: 4'b0101, blz: 1'b0, segs: {HA, HB, HC, HD}, edp: 4'b0101};
      tbl[3] = '{value: 16'h0000, dp: 4'b0000, blz: 1'b1, segs: {BLK, BLK, BLK, H0}, edp: 4'b0000};
      tbl[4] = '{value: 16'h6789, dp: 4'b0010, blz: 1'b1, segs: {H6, H7, H8, H9}, edp: 4'b0010};
      tbl[5] = '{value: 16'h0FE0, dp: 4'b0000, blz: 1'b1, segs: {BLK, HF, HE, H0}, edp: 4'b0000};
      tbl[6] = '{value: 16'h1234, dp: 4'b0000, blz: 1'b0, segs: {H1, H2, H3, H4}, edp: 4'b0000};
      step(2);
      drive_chk("reset", 4'b0000, BLK);
      chk("reset_dp", 32'(dp_out), 32'd0);
      chk("reset_fd", 32'(frame_done), 32'd0);
      chk("reset_pending", 32'(pending), 32'd0);
      rst_n = 1'b1;
      en    = 1'b1;
      for (int v = 0; v < 7; v++) begin
         blank_lz = tbl[v].blz;
         value    = tbl[v].value;
         dp_in    = tbl[v].dp;
         load     = 1'b1;
         step();
         load = 1'b0;
         chk("vec_pending_set", 32'(pending), 32'd1);
         wait_fd();
         chk("vec_pending_clr", 32'(pending), 32'd0);
         for (int k = 0; k < 4; k++) begin
            step();
            drive_chk("vec_guard", 4'b0000, BLK);
            if (k == 0) chk("vec_fd_low", 32'(frame_done), 32'd0);
            step(2);
            drive_chk("vec_first", 4'(1 << k), tbl[v].segs[7*k +: 7]);
            chk("vec_first_dp", 32'(dp_out), 32'(tbl[v].edp[k]));
            step(5);
            drive_chk("vec_last", 4'(1 << k), tbl[v].segs[7*k +: 7]);
            chk("vec_last_dp", 32'(dp_out), 32'(tbl[v].edp[k]));
         end
         chk("vec_fd_period", 32'(frame_done), 32'd1);
      end
      // mid-frame load must not tear the current frame
      step(11);
      drive_chk("mid_d1_before", 4'b0010, H3);
      value = 16'h5555;
      dp_in = 4'b0000;
      load  = 1'b1;
      step();
      load = 1'b0;
      chk("mid_pending", 32'(pending), 32'd1);
      drive_chk("mid_d1_after", 4'b0010, H3);
      step(8);
      drive_chk("mid_d2", 4'b0100, H2);
      step(8);
      drive_chk("mid_d3", 4'b1000, H1);
      step(4);
      chk("mid_fd", 32'(frame_done), 32'd1);
      chk("mid_pending_clr", 32'(pending), 32'd0);
      step(3);
      drive_chk("mid_next_d0", 4'b0001, H5);
      // loads one cycle before and in the boundary cycle
      step(27);
      value = 16'h1111;
      load  = 1'b1;
      step();
      chk("bnd_pre_pending", 32'(pending), 32'd1);
      chk("bnd_pre_fd", 32'(frame_done), 32'd0);
      value = 16'h2222;
      step();
      load = 1'b0;
      chk("bnd_fd", 32'(frame_done), 32'd1);
      chk("bnd_pending", 32'(pending), 32'd0);
      step(3);
      drive_chk("bnd_d0", 4'b0001, H2);
      // drop enable at counter 5 of digit 2
      step(18);
      drive_chk("en_before", 4'b0100, H2);
      en = 1'b0;
      step();
      drive_chk("en_dark", 4'b0000, BLK);
      chk("en_dark_dp", 32'(dp_out), 32'd0);
      chk("en_dark_fd", 32'(frame_done), 32'd0);
      value = 16'h00A7;
      load  = 1'b1;
      step();
      load = 1'b0;
      chk("en_off_load_pending", 32'(pending), 32'd0);
      fd_seen  = 1'b0;
      sel_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         fd_seen  = fd_seen | frame_done;
         sel_seen = sel_seen | (|digit_sel);
      end
      chk("en_off_no_fd", 32'(fd_seen), 32'd0);
      chk("en_off_no_sel", 32'(sel_seen), 32'd0);
      en = 1'b1;
      step();
      drive_chk("reen_g0", 4'b0000, BLK);
      step();
      drive_chk("reen_g1", 4'b0000, BLK);
      step();
      drive_chk("reen_d0", 4'b0001, H7);
      // an existing pending value commits on the first disabled cycle
      value = 16'h0003;
      load  = 1'b1;
      step();
      load = 1'b0;
      chk("drop_pending_set", 32'(pending), 32'd1);
      en = 1'b0;
      step();
      chk("drop_pending_clr", 32'(pending), 32'd0);
      en = 1'b1;
      step(3);
      drive_chk("drop_d0", 4'b0001, H3);
      // asynchronous reset mid-DRIVE
      value = 16'h4444;
      load  = 1'b1;
      step();
      load = 1'b0;
      chk("rst_pre_pending", 32'(pending), 32'd1);
      rst_n = 1'b0;
      #2;
      drive_chk("rst_async", 4'b0000, BLK);
      chk("rst_async_pending", 32'(pending), 32'd0);
      #3;
      rst_n = 1'b1;
      step(3);
      drive_chk("rst_after_d0", 4'b0001, H0);
      chk("rst_after_pending", 32'(pending), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
